// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the memory request sequencer.
//   AW_DEF / DW_DEF        : default address and data widths of the word memory
//   REQ_DEPTH_DEF          : default request queue depth
//   RESP_DEPTH_DEF         : default read-response buffer depth
//   OP_READ / OP_WRITE     : request opcode, identical to the memory's RW encoding
package mem_req_ctrl_pkg;

    localparam int AW_DEF         = 8;
    localparam int DW_DEF         = 32;
    localparam int REQ_DEPTH_DEF  = 4;
    localparam int RESP_DEPTH_DEF = 2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_ctrl_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
//   CLK, RESET : clock, asynchronous active-high reset (clears pointers/count)
//   push/wdata : write side; a push into a full FIFO is dropped unless
//                PUSH_WHEN_FULL_POP is set and a pop happens on the same edge
//   pop/rdata  : read side; rdata is the current head (not valid when empty)
//   full/empty/count : status derived from the registered count only
module mem_ctrl_fifo #(
    parameter int DEPTH              = 4,
    parameter int W                  = 8,
    parameter bit PUSH_WHEN_FULL_POP = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  storage [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || (PUSH_WHEN_FULL_POP && do_pop));
        // DEPTH is a power of two, so pointers wrap on natural overflow.
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            storage[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = storage[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of the 32-bit word memory (1-cycle registered read).
//   CLK, RESET   : clock, asynchronous active-high reset (shared with the memory)
//   req_*        : client request queue (valid/ready, rw, addr, wdata)
//   resp_*       : in-order read responses (valid/ready, rdata)
//   mem_valid/mem_rw/mem_addr/mem_din : access issued to the memory this cycle
//   mem_dout     : memory read data, one cycle after a read issues
// At most one access issues per cycle, straight from the request queue head.
// Reads issue only when the response buffer is guaranteed room for the data.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int REQ_DEPTH  = REQ_DEPTH_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rw,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          mem_valid,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int RQW = 1 + AW + DW;
    // One bit wider than the response count so count + rd_pending cannot wrap.
    localparam int CRW = $clog2(RESP_DEPTH) + 2;

    logic [RQW-1:0]                 req_word, head_word;
    logic                           req_full, req_empty;
    logic [$clog2(REQ_DEPTH):0]     unused_req_count;
    logic                           head_rw;
    logic [AW-1:0]                  head_addr;
    logic [DW-1:0]                  head_wdata;

    logic                           resp_empty, unused_resp_full;
    logic [$clog2(RESP_DEPTH):0]    resp_count;
    logic                           resp_pop;

    logic                           rd_pending_q, rd_pending_d;
    logic [CRW-1:0]                 reads_owed;
    logic                           read_credit;
    logic                           issue;

    assign req_word   = {req_rw, req_addr, req_wdata};
    assign head_rw    = head_word[RQW-1];
    assign head_addr  = head_word[DW +: AW];
    assign head_wdata = head_word[DW-1:0];

    // Request queue: the FIFO drops pushes when full, so req_valid feeds it directly.
    mem_ctrl_fifo #(
        .DEPTH              (REQ_DEPTH),
        .W                  (RQW),
        .PUSH_WHEN_FULL_POP (1'b0)
    ) u_req_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (req_valid),
        .wdata (req_word),
        .pop   (issue),
        .rdata (head_word),
        .full  (req_full),
        .empty (req_empty),
        .count (unused_req_count)
    );

    assign req_ready = !req_full;

    // Reads owed to the response buffer after this edge: what is buffered, plus
    // the read already at the memory, minus the entry the client takes now.
    always_comb begin
        reads_owed  = CRW'(resp_count) + CRW'(rd_pending_q) - CRW'(resp_pop);
        read_credit = (reads_owed < CRW'(RESP_DEPTH));
        issue       = !req_empty && ((head_rw == OP_WRITE) || read_credit);
    end

    // Idle memory outputs are forced to zero rather than showing the head.
    always_comb begin
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (issue) begin
            mem_valid = 1'b1;
            mem_rw    = head_rw;
            mem_addr  = head_addr;
            mem_din   = head_wdata;
        end
    end

    // rd_pending marks the cycle in which mem_dout holds data for a read.
    always_comb begin
        rd_pending_d = issue && (head_rw == OP_READ);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= rd_pending_d;
        end
    end

    assign resp_pop   = resp_valid && resp_ready;
    assign resp_valid = !resp_empty;

    // Credit accounting keeps this buffer from overflowing; push-on-full is
    // still allowed when the client pops on the same edge.
    mem_ctrl_fifo #(
        .DEPTH              (RESP_DEPTH),
        .W                  (DW),
        .PUSH_WHEN_FULL_POP (1'b1)
    ) u_resp_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (rd_pending_q),
        .wdata (mem_dout),
        .pop   (resp_pop),
        .rdata (resp_rdata),
        .full  (unused_resp_full),
        .empty (resp_empty),
        .count (resp_count)
    );

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid, req_ready, req_rw;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_rw;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;

    int errors = 0;
    int checks = 0;

    logic [31:0] got [$];
    logic [31:0] expq [$];

    always #5 CLK = ~CLK;

    mem_req_ctrl #(.AW(8), .DW(32), .REQ_DEPTH(4), .RESP_DEPTH(2)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .mem_valid  (mem_valid),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Word memory model: registered read, cleared by the shared reset.
    logic [31:0] mem_arr [256];
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
            mem_dout <= '0;
        end else if (mem_valid) begin
            if (mem_rw) mem_arr[mem_addr] <= mem_din;
            else        mem_dout <= mem_arr[mem_addr];
        end
    end

    // Record every response handshake that will complete on the next edge.
    always @(negedge CLK) begin
        if (!RESET && resp_valid && resp_ready) got.push_back(resp_rdata);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Present one request and return just after the edge that accepts it.
    task automatic send(input logic rw, input logic [7:0] a, input logic [31:0] d);
        int w;
        w = 0;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && w < 50) begin
            step();
            w++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual req_ready=0 after %0d cycles, required 1", w);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic compare_responses(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            check($sformatf("%s_%0d", name, i), got[i], expq[i]);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 8'h11, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 8'h11, 32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 8'h12, 32'h0,        32'h00000000};
        vecs[5] = '{1'b1, 8'h10, 32'hFFFFFFFF, 32'h0};
        vecs[6] = '{1'b0, 8'h10, 32'h0,        32'hFFFFFFFF};
        vecs[7] = '{1'b1, 8'hFF, 32'h00000001, 32'h0};
        vecs[8] = '{1'b0, 8'hFF, 32'h0,        32'h00000001};

        RESET      = 1'b1;
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        step();
        step();
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_valid",  32'(mem_valid),  32'd0);
        check("rst_mem_rw",     32'(mem_rw),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_din",    mem_din,         32'd0);
        RESET = 1'b0;
        step();

        // Single accesses from an empty queue: exact issue and response timing.
        for (int v = 0; v < 9; v++) begin
            send(vecs[v].rw, vecs[v].addr, vecs[v].wdata);
            check($sformatf("v%0d_c0_mem_valid", v), 32'(mem_valid), 32'd1);
            check($sformatf("v%0d_c0_mem_rw", v),    32'(mem_rw),    32'(vecs[v].rw));
            check($sformatf("v%0d_c0_mem_addr", v),  32'(mem_addr),  32'(vecs[v].addr));
            if (vecs[v].rw) check($sformatf("v%0d_c0_mem_din", v), mem_din, vecs[v].wdata);
            step();
            check($sformatf("v%0d_c1_mem_valid", v),  32'(mem_valid),  32'd0);
            check($sformatf("v%0d_c1_resp_valid", v), 32'(resp_valid), 32'd0);
            step();
            check($sformatf("v%0d_c2_resp_valid", v), 32'(resp_valid), 32'(!vecs[v].rw));
            if (!vecs[v].rw) check($sformatf("v%0d_c2_rdata", v), resp_rdata, vecs[v].exp);
            step();
            check($sformatf("v%0d_c3_resp_valid", v), 32'(resp_valid), 32'd0);
        end

        // Back-to-back reads after reset: one issue and one response per cycle.
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        step();
        got.delete();
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 8'(k), 32'h0);
            check($sformatf("stream_c%0d_mem_valid", k),  32'(mem_valid),  32'd1);
            check($sformatf("stream_c%0d_mem_addr", k),   32'(mem_addr),   32'(k));
            check($sformatf("stream_c%0d_resp_valid", k), 32'(resp_valid), 32'(k >= 2));
        end
        for (int k = 4; k < 8; k++) begin
            step();
            check($sformatf("stream_c%0d_mem_valid", k),  32'(mem_valid),  32'd0);
            check($sformatf("stream_c%0d_resp_valid", k), 32'(resp_valid), 32'(k < 6));
            if (k < 6) check($sformatf("stream_c%0d_rdata", k), resp_rdata, 32'h0);
        end
        expq.delete();
        for (int k = 0; k < 4; k++) expq.push_back(32'h0);
        compare_responses("stream_resp");

        // Backpressure: only RESP_DEPTH reads go out while the client stalls.
        for (int i = 0; i < 6; i++) send(1'b1, 8'h20 + 8'(i), 32'h1000 + 32'(i));
        step();
        step();
        got.delete();
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b0, 8'h20 + 8'(i), 32'h0);
        check("bp_req_ready",  32'(req_ready),  32'd0);
        check("bp_mem_valid",  32'(mem_valid),  32'd0);
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        check("bp_rdata_head", resp_rdata,      32'h1000);
        step();
        step();
        check("bp_hold_req_ready", 32'(req_ready), 32'd0);
        check("bp_hold_mem_valid", 32'(mem_valid), 32'd0);
        resp_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        expq.delete();
        for (int i = 0; i < 6; i++) expq.push_back(32'h1000 + 32'(i));
        compare_responses("bp_resp");
        check("bp_drained_req_ready", 32'(req_ready), 32'd1);

        // Ordering: a read queued ahead of a write sees the old data.
        got.delete();
        send(1'b0, 8'h30, 32'h0);
        send(1'b1, 8'h30, 32'hA5A5A5A5);
        send(1'b0, 8'h30, 32'h0);
        for (int i = 0; i < 8; i++) step();
        expq.delete();
        expq.push_back(32'h00000000);
        expq.push_back(32'hA5A5A5A5);
        compare_responses("order_resp");

        // Reset with two responses buffered and three requests queued.
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 8'h20 + 8'(i), 32'h0);
        step();
        check("prerst_resp_valid", 32'(resp_valid), 32'd1);
        check("prerst_mem_valid",  32'(mem_valid),  32'd0);
        RESET = 1'b1;
        #1;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_req_ready",  32'(req_ready),  32'd1);
        check("midrst_mem_valid",  32'(mem_valid),  32'd0);
        check("midrst_mem_addr",   32'(mem_addr),   32'd0);
        step();
        step();
        RESET = 1'b0;
        got.delete();
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("postrst_no_stale", 32'(got.size()), 32'd0);
        check("postrst_resp_valid", 32'(resp_valid), 32'd0);
        send(1'b0, 8'h20, 32'h0);
        for (int i = 0; i < 6; i++) step();
        expq.delete();
        expq.push_back(32'h0);
        compare_responses("postrst_resp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request sequencer directly upstream of the 32-bit word memory. It sits between a client such as the load/store stage and the memory's Valid/RW/Addr/Din/D_OUT interface.
- Client side: queued requests with valid/ready, plus an in-order read-response channel.
- Memory side: at most one access is issued per cycle. The block tracks the memory's 1-cycle registered read latency and never overflows its response buffer.

Parameters:
AW, 8, memory address width; must match the memory's WIDTH
DW, 32, data width
REQ_DEPTH, 4, request FIFO entries (power of 2, >=2)
RESP_DEPTH, 2, read-response FIFO entries (power of 2, >=2)

Ports:
CLK  in  1  clock
RESET  in  1  reset
req_valid  in  1  client request valid
req_ready  out  1  request FIFO not full
req_rw  in  1  1=write, 0=read
req_addr  in  AW  word address
req_wdata  in  DW  write data
resp_valid  out  1  read data available
resp_ready  in  1  client accepts read data
resp_rdata  out  DW  read data, in request order
mem_valid  out  1  to memory Valid
mem_rw  out  1  to memory RW
mem_addr  out  AW  to memory Addr
mem_din  out  DW  to memory Din
mem_dout  in  DW  from memory D_OUT

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is CLK. Reset clears FIFO pointers/counts and rd_pending.
  - During and after reset: req_ready=1 (FIFO empty), resp_valid=0, mem_valid=0; mem_rw/mem_addr/mem_din=0.
  - Reset mid-operation discards queued, in-flight and buffered requests; no response is ever produced for them. RESET is shared with the memory.
- Request accept: a request is pushed on an edge where req_valid && req_ready. req_ready = !req_full, from registered count only.
  - Full FIFO blocks a push even if a pop happens the same cycle.
- Issue (combinational from the FIFO head): issue = !req_empty && (head.rw || read_credit).
  - read_credit = (resp_count + rd_pending - (resp_valid && resp_ready)) < RESP_DEPTH.
  - When issuing: mem_valid=1 and mem_rw/mem_addr/mem_din equal the head fields; the head pops on that edge.
  - When not issuing: mem_valid=0 and the other memory outputs hold the head fields or 0; the memory must ignore them.
- Read tracking: rd_pending is set on the edge a read issues and is cleared otherwise. While rd_pending=1, mem_dout is pushed into the response FIFO on the next edge.
  - mem_dout is never sampled when rd_pending=0.
- Timing: request accepted at edge 0 -> mem_valid in cycle 0 (FIFO was empty) -> memory registers at edge 1 -> captured at edge 2 -> resp_valid in cycle 2.
- Writes produce no response. A write issued at edge n is visible to a read issued at edge n+1 or later.
- Ordering: strictly in order. A read queued before a write to the same address returns the old data.
- Throughput: with resp_ready held high, one access per cycle sustained, reads included.
- Backpressure: with resp_ready low, at most RESP_DEPTH reads are in flight plus buffered. Further reads stall at the head and also block writes queued behind them.
- Response FIFO: resp_valid = !resp_empty; resp_rdata = head data; pops on resp_valid && resp_ready.
  - Overflow is impossible by the credit rule. A simultaneous push and pop on a full FIFO is legal.
- There is a combinational path resp_ready -> mem_valid; this is accepted.

Decomposition:
- Shared package: AW/DW defaults and constants OP_READ=1'b0, OP_WRITE=1'b1, matching the memory's RW encoding.
- Sub-module mem_ctrl_fifo is a generic synchronous FIFO: parameters DEPTH and W; outputs full, empty, count; asynchronous RESET. It is instantiated twice:
  - request FIFO, W = 1+AW+DW;
  - response FIFO, W = DW.

Test Plan:
- Write 0x10=0xDEADBEEF, then read 0x10 with resp_ready=1 -> resp_rdata=0xDEADBEEF with resp_valid exactly 2 cycles after the read acceptance edge (FIFO initially empty).
- After reset, read addresses 0x00..0x03 back-to-back with resp_ready=1 -> mem_valid high 4 consecutive cycles, 4 responses of 0x00000000 on 4 consecutive cycles.
- Write 0x20..0x25 = 0x1000+i. Then, with resp_ready=0, push 6 reads of 0x20..0x25 -> only 2 issued; FIFO holds 4; req_ready=0. Raise resp_ready -> 6 responses 0x1000..0x1005 in order, no loss or duplication.
- Queue read 0x30, write 0x30=0xA5A5A5A5, read 0x30 (old value 0) -> responses 0x00000000 then 0xA5A5A5A5.
- Assert RESET while 2 reads are buffered and 3 requests are queued -> resp_valid=0, req_ready=1, mem_valid=0 immediately. No stale response ever appears; later read of 0x20 returns 0.
